// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake, transmitter drive and status signals of the UART TX arbiter
interface uart_tx_arbiter_if #(
    parameter int Data_Len = 8,
    parameter int NUM_REQ  = 4
);
    logic [NUM_REQ-1:0]          REQ_VALID;
    logic [NUM_REQ*Data_Len-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]          REQ_READY;
    logic [NUM_REQ-1:0]          PAR_EN_CFG;
    logic [NUM_REQ-1:0]          PAR_TYP_CFG;
    logic                        TX_BUSY;
    logic [Data_Len-1:0]         P_DATA;
    logic                        Data_Valid;
    logic                        PAR_EN;
    logic                        PAR_TYP;
    logic [$clog2(NUM_REQ)-1:0]  GRANT_ID;
    logic                        ARB_BUSY;
    logic                        TX_ERR;

    modport master (
        output REQ_VALID, REQ_DATA, PAR_EN_CFG, PAR_TYP_CFG, TX_BUSY,
        input  REQ_READY, P_DATA, Data_Valid, PAR_EN, PAR_TYP, GRANT_ID, ARB_BUSY, TX_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_DATA, PAR_EN_CFG, PAR_TYP_CFG, TX_BUSY,
        output REQ_READY, P_DATA, Data_Valid, PAR_EN, PAR_TYP, GRANT_ID, ARB_BUSY, TX_ERR
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NUM_REQ requesters
module uart_tx_arbiter #(
    parameter int Data_Len     = 8,
    parameter int NUM_REQ      = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int BUSY_TIMEOUT = 4
) (
    input logic CLK,
    input logic RST,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic            hit;
    logic [IW:0]     j;
    logic [TW-1:0]   tmo;
    logic [GW-1:0]   gap;

    // first requesting index after the pointer, scanned with wrap; lowest offset wins
    always_comb begin
        j   = '0;
        hit = 1'b0;
        win = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = {1'b0, ptr} + (IW+1)'(k);
            if (j >= (IW+1)'(NUM_REQ)) j = j - (IW+1)'(NUM_REQ);
            if (bus.REQ_VALID[j[IW-1:0]]) begin
                hit = 1'b1;
                win = j[IW-1:0];
            end
        end
    end

    // grant, issue, busy framing and gap sequencing with all outputs registered
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state          <= IDLE;
            ptr            <= IW'(NUM_REQ - 1);
            tmo            <= '0;
            gap            <= '0;
            bus.P_DATA     <= '0;
            bus.Data_Valid <= 1'b0;
            bus.PAR_EN     <= 1'b0;
            bus.PAR_TYP    <= 1'b0;
            bus.REQ_READY  <= '0;
            bus.GRANT_ID   <= '0;
            bus.ARB_BUSY   <= 1'b0;
            bus.TX_ERR     <= 1'b0;
        end else begin
            bus.REQ_READY  <= '0;
            bus.Data_Valid <= 1'b0;
            bus.TX_ERR     <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit && !bus.TX_BUSY) begin
                        bus.P_DATA    <= bus.REQ_DATA[win*Data_Len +: Data_Len];
                        bus.PAR_EN    <= bus.PAR_EN_CFG[win];
                        bus.PAR_TYP   <= bus.PAR_TYP_CFG[win];
                        bus.GRANT_ID  <= win;
                        bus.REQ_READY <= NUM_REQ'(1) << win;
                        bus.ARB_BUSY  <= 1'b1;
                        ptr           <= win;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.Data_Valid <= 1'b1;
                    tmo            <= '0;
                    state          <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.TX_BUSY) begin
                        state <= WAIT_DONE;
                    end else if (tmo == TW'(BUSY_TIMEOUT - 1)) begin
                        bus.TX_ERR   <= 1'b1;
                        bus.ARB_BUSY <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.TX_BUSY) begin
                        if (GAP_CYCLES > 0) begin
                            gap   <= '0;
                            state <= GAP;
                        end else begin
                            bus.ARB_BUSY <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap == GW'(GAP_CYCLES - 1)) begin
                        bus.ARB_BUSY <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                default: begin
                    bus.ARB_BUSY <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of the UART TX arbiter against a transaction-level model
module tb_uart_tx_arbiter;
    localparam int DL  = 8;
    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int TMO = 4;

    logic CLK = 1'b0;
    logic RST;
    logic force_busy = 1'b0;
    logic tx_en = 1'b1;
    int   busy_cnt = 0;
    logic [10:0] frame = '1;
    logic tx_line;

    int checks = 0;
    int errors = 0;
    int rr = N - 1;
    int rdy_cnt = 0;
    int dv_cnt = 0;
    logic pend = 1'b0;
    logic l_rst = 1'b0;
    logic l_busy = 1'b0;
    logic [N-1:0] l_valid = '0;
    logic [N*DL-1:0] l_data = '0;
    logic [N-1:0] l_pen = '0;
    logic [N-1:0] l_ptyp = '0;
    logic [DL-1:0] l_pdata = '0;

    uart_tx_arbiter_if #(.Data_Len(DL), .NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.Data_Len(DL), .NUM_REQ(N), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    assign bus.TX_BUSY = (busy_cnt != 0) || force_busy;
    assign tx_line = (busy_cnt == 0) ? 1'b1 : frame[4'(11 - busy_cnt)];

    // transmitter model: 11-clock frame (start, 8 data, parity, stop) per Data_Valid, shares RST
    always @(posedge CLK) begin
        if (!RST) busy_cnt <= 0;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        else if (bus.Data_Valid && tx_en) begin
            busy_cnt <= 11;
            frame <= {1'b1, bus.PAR_EN ? ((^bus.P_DATA) ^ bus.PAR_TYP) : 1'b1, bus.P_DATA, 1'b0};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // scoreboard: every grant must match round-robin over the inputs seen at the grant edge
    always @(negedge CLK) begin : mon
        int w;
        if (!l_rst) begin
            rr = N - 1;
            pend = 1'b0;
        end else begin
            w = pick(l_valid, rr);
            if (bus.REQ_READY != '0) begin
                chk("mon_ready", 32'(bus.REQ_READY), (w < 0) ? 32'd0 : 32'(1 << w));
                if (w >= 0) begin
                    chk("mon_gid", 32'(bus.GRANT_ID), 32'(w));
                    chk("mon_pdata", 32'(bus.P_DATA), 32'(l_data[w*DL +: DL]));
                    chk("mon_pen", 32'(bus.PAR_EN), 32'(l_pen[w]));
                    chk("mon_ptyp", 32'(bus.PAR_TYP), 32'(l_ptyp[w]));
                    rr = w;
                end
                rdy_cnt++;
            end
            chk("mon_dv", 32'(bus.Data_Valid), 32'(pend));
            if (bus.TX_BUSY && l_busy) chk("mon_hold", 32'(bus.P_DATA), 32'(l_pdata));
            pend = (bus.REQ_READY != '0);
            if (bus.Data_Valid) dv_cnt++;
        end
        l_rst   = RST;
        l_busy  = bus.TX_BUSY;
        l_valid = bus.REQ_VALID;
        l_data  = bus.REQ_DATA;
        l_pen   = bus.PAR_EN_CFG;
        l_ptyp  = bus.PAR_TYP_CFG;
        l_pdata = bus.P_DATA;
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_ready(input string tag, input int lim, output int n);
        n = 0;
        while (bus.REQ_READY == '0 && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < lim), 32'd1);
    endtask

    task automatic wait_busy(input string tag, input logic lvl, input int lim, output int n);
        n = 0;
        while (bus.TX_BUSY !== lvl && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < lim), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n;
        n = 0;
        while (bus.ARB_BUSY !== 1'b0 && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < lim), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        logic par_bit;
        logic hold_ok;
        RST = 1'b0;
        bus.REQ_VALID   = 4'hF;
        bus.REQ_DATA    = 32'h44332211;
        bus.PAR_EN_CFG  = '0;
        bus.PAR_TYP_CFG = '0;
        tick();
        tick();
        chk("rst_pdata", 32'(bus.P_DATA), 32'd0);
        chk("rst_dv", 32'(bus.Data_Valid), 32'd0);
        chk("rst_pen", 32'(bus.PAR_EN), 32'd0);
        chk("rst_ptyp", 32'(bus.PAR_TYP), 32'd0);
        chk("rst_ready", 32'(bus.REQ_READY), 32'd0);
        chk("rst_gid", 32'(bus.GRANT_ID), 32'd0);
        chk("rst_arb_busy", 32'(bus.ARB_BUSY), 32'd0);
        chk("rst_err", 32'(bus.TX_ERR), 32'd0);
        RST = 1'b1;
        wait_ready("first_ready_seen", 10, n);
        chk("first_ready", 32'(bus.REQ_READY), 32'h1);
        chk("first_gid", 32'(bus.GRANT_ID), 32'd0);
        tick();
        chk("first_dv", 32'(bus.Data_Valid), 32'd1);
        // busy low seen in WAIT_DONE, GAP clocks, one IDLE grant clock, then READY
        for (int g = 1; g <= 4; g++) begin
            wait_busy("rr_busy_hi", 1'b1, 20, n);
            wait_busy("rr_busy_lo", 1'b0, 20, n);
            wait_ready("rr_ready_seen", 20, n);
            chk("rr_gap", 32'(n), 32'(GAP + 2));
            chk("rr_gid", 32'(bus.GRANT_ID), 32'(g % 4));
            chk("rr_pdata", 32'(bus.P_DATA), 32'((g % 4 + 1) * 17));
        end
        bus.REQ_VALID = '0;
        wait_idle("rr_idle", 40);

        bus.PAR_EN_CFG  = 4'b0100;
        bus.PAR_TYP_CFG = 4'b0100;
        bus.REQ_DATA[23:16] = 8'hA5;
        bus.REQ_VALID = 4'b0100;
        wait_ready("par_ready_seen", 10, n);
        chk("par_ready", 32'(bus.REQ_READY), 32'h4);
        chk("par_en", 32'(bus.PAR_EN), 32'd1);
        chk("par_typ", 32'(bus.PAR_TYP), 32'd1);
        chk("par_pdata", 32'(bus.P_DATA), 32'hA5);
        bus.REQ_VALID = '0;
        wait_busy("par_busy_hi", 1'b1, 10, n);
        par_bit = 1'b0;
        hold_ok = 1'b1;
        cnt = 0;
        while (bus.TX_BUSY && cnt < 20) begin
            if (busy_cnt == 2) par_bit = tx_line;
            if (bus.P_DATA != 8'hA5 || !bus.PAR_EN || !bus.PAR_TYP) hold_ok = 1'b0;
            tick();
            cnt++;
        end
        chk("par_hold", 32'(hold_ok), 32'd1);
        chk("par_line_bit", 32'(par_bit), 32'd1);
        wait_idle("par_idle", 20);

        tx_en = 1'b0;
        bus.REQ_VALID = 4'b1000;
        wait_ready("tmo_ready_seen", 10, n);
        chk("tmo_ready", 32'(bus.REQ_READY), 32'h8);
        bus.REQ_VALID = '0;
        tick();
        chk("tmo_dv", 32'(bus.Data_Valid), 32'd1);
        n = 0;
        while (!bus.TX_ERR && n < 10) begin
            tick();
            n++;
        end
        chk("tmo_delay", 32'(n), 32'(TMO));
        chk("tmo_arb_idle", 32'(bus.ARB_BUSY), 32'd0);
        tick();
        chk("tmo_pulse_end", 32'(bus.TX_ERR), 32'd0);
        tx_en = 1'b1;
        bus.REQ_VALID = 4'b0110;
        wait_ready("tmo_next_seen", 10, n);
        chk("tmo_next", 32'(bus.REQ_READY), 32'h2);
        bus.REQ_VALID = '0;
        wait_idle("tmo_idle", 30);

        force_busy = 1'b1;
        bus.REQ_VALID = 4'b0010;
        cnt = 0;
        repeat (6) begin
            tick();
            if (bus.REQ_READY != '0) cnt++;
        end
        chk("blk_none", 32'(cnt), 32'd0);
        force_busy = 1'b0;
        wait_ready("blk_ready_seen", 5, n);
        chk("blk_ready", 32'(bus.REQ_READY), 32'h2);
        bus.REQ_VALID = '0;
        wait_idle("blk_idle", 30);

        force_busy = 1'b1;
        bus.REQ_VALID = 4'b0101;
        repeat (3) tick();
        bus.REQ_VALID = 4'b0001;
        force_busy = 1'b0;
        wait_ready("skip_ready_seen", 5, n);
        chk("skip_ready", 32'(bus.REQ_READY), 32'h1);
        bus.REQ_VALID = '0;
        wait_idle("skip_idle", 30);

        bus.REQ_VALID = 4'b0100;
        wait_ready("mrst_ready_seen", 10, n);
        chk("mrst_grant", 32'(bus.REQ_READY), 32'h4);
        bus.REQ_VALID = '0;
        wait_busy("mrst_busy_hi", 1'b1, 10, n);
        tick();
        tick();
        RST = 1'b0;
        tick();
        chk("mrst_dv", 32'(bus.Data_Valid), 32'd0);
        chk("mrst_arb_busy", 32'(bus.ARB_BUSY), 32'd0);
        chk("mrst_ready", 32'(bus.REQ_READY), 32'd0);
        chk("mrst_pdata", 32'(bus.P_DATA), 32'd0);
        bus.REQ_VALID = 4'b1101;
        RST = 1'b1;
        wait_ready("mrst_next_seen", 10, n);
        chk("mrst_next", 32'(bus.REQ_READY), 32'h1);
        bus.REQ_VALID = '0;
        wait_idle("mrst_idle", 30);

        rdy_cnt = 0;
        dv_cnt = 0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.REQ_READY[i]) bus.REQ_VALID[i] = 1'b0;
                else if (!bus.REQ_VALID[i] && $urandom_range(3) == 0) begin
                    bus.REQ_VALID[i] = 1'b1;
                    bus.REQ_DATA[i*DL +: DL] = 8'($urandom);
                    bus.PAR_EN_CFG[i] = 1'($urandom);
                    bus.PAR_TYP_CFG[i] = 1'($urandom);
                end else if (bus.REQ_VALID[i] && $urandom_range(15) == 0) bus.REQ_VALID[i] = 1'b0;
            end
            tick();
        end
        bus.REQ_VALID = '0;
        wait_idle("rand_idle", 60);
        tick();
        tick();
        chk("rand_ready_dv", 32'(rdy_cnt), 32'(dv_cnt));
        chk("rand_grants", 32'(rdy_cnt > 10), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
